// File: rtl/chan_read_sched.sv
// Round-robin read scheduler for the per-channel FIFOs feeding the output mux.
// Skips empty channels, grants bounded bursts and honours downstream backpressure.
module chan_read_sched #(
  parameter int NCH       = 80,
  parameter int CHW       = 7,
  parameter int MAX_BURST = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           stop_i,
  input  logic [NCH-1:0] fifo_empty_i,
  input  logic           out_ready_i,
  output logic [NCH-1:0] fifo_read_enable_o,
  output logic [CHW-1:0] chid_value_o,
  output logic           data_valid_o,
  output logic [CHW-1:0] data_chid_o,
  output logic           busy_o
);

  typedef enum logic [1:0] {IDLE, ARB, BURST} state_t;

  state_t         state_q;
  logic [CHW-1:0] ptr_q;
  logic [CHW-1:0] chid_q;
  logic [3:0]     beats_q;
  logic           dataValid_q;
  logic [CHW-1:0] dataChid_q;

  logic           hit;
  logic [CHW-1:0] hitIdx;
  logic [CHW:0]   sum;
  logic           rd;
  logic           chanEmpty;
  logic [CHW-1:0] ptr_d;

  // Walk offsets from farthest to nearest so the nearest non-empty channel wins.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    sum    = '0;
    for (int off = NCH - 1; off >= 0; off--) begin
      sum = {1'b0, ptr_q} + (CHW + 1)'(off);
      if (sum >= (CHW + 1)'(NCH)) begin
        sum = sum - (CHW + 1)'(NCH);
      end
      if (!fifo_empty_i[sum[CHW-1:0]]) begin
        hit    = 1'b1;
        hitIdx = sum[CHW-1:0];
      end
    end
  end

  // The strobe is held off during reset so an aborted burst never pops a word.
  always_comb begin
    chanEmpty          = fifo_empty_i[chid_q];
    rd                 = rst_i && (state_q == BURST) && out_ready_i && !chanEmpty;
    fifo_read_enable_o = '0;
    if (rd) begin
      fifo_read_enable_o = {{(NCH - 1){1'b0}}, 1'b1} << chid_q;
    end
    ptr_d = (chid_q == CHW'(NCH - 1)) ? '0 : chid_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      chid_q      <= '0;
      beats_q     <= '0;
      dataValid_q <= 1'b0;
      dataChid_q  <= '0;
    end else begin
      dataValid_q <= rd;
      dataChid_q  <= chid_q;
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= ARB;
          end
        end
        ARB: begin
          if (stop_i) begin
            state_q <= IDLE;
          end else if (hit) begin
            chid_q  <= hitIdx;
            beats_q <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (rd) begin
            beats_q <= beats_q + 1'b1;
          end
          if (stop_i) begin
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else if ((rd && beats_q == 4'(MAX_BURST - 1)) || chanEmpty) begin
            ptr_q   <= ptr_d;
            state_q <= ARB;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chid_value_o = chid_q;
  assign data_valid_o = dataValid_q;
  assign data_chid_o  = dataChid_q;
  assign busy_o       = (state_q != IDLE) || dataValid_q;

endmodule

// File: tb/tb_chan_read_sched.sv
// Self-checking bench for chan_read_sched: directed scenarios plus random traffic,
// compared every cycle against a FIFO-count based reference model.
module tb_chan_read_sched;

  localparam int NCH       = 80;
  localparam int CHW       = 7;
  localparam int MAX_BURST = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           stop;
  logic           outReady;
  logic [NCH-1:0] fifoEmpty;
  logic [NCH-1:0] fifoReadEnable;
  logic [CHW-1:0] chidValue;
  logic           dataValid;
  logic [CHW-1:0] dataChid;
  logic           busy;

  int errors = 0;
  int checks = 0;

  // Words waiting in each channel FIFO
  int cnt[NCH];

  // Reference model: mode 0=idle, 1=searching, 2=serving channel mChan
  int mMode  = 0;
  int mPtr   = 0;
  int mChan  = 0;
  int mReads = 0;
  int mDv    = 0;
  int mDchid = 0;

  int strobeLog[$];

  always #5 clk = ~clk;

  chan_read_sched #(.NCH(NCH), .CHW(CHW), .MAX_BURST(MAX_BURST)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .start_i            (start),
    .stop_i             (stop),
    .fifo_empty_i       (fifoEmpty),
    .out_ready_i        (outReady),
    .fifo_read_enable_o (fifoReadEnable),
    .chid_value_o       (chidValue),
    .data_valid_o       (dataValid),
    .data_chid_o        (dataChid),
    .busy_o             (busy)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int firstNonEmpty(input int from);
    for (int k = 0; k < NCH; k++) begin
      if (cnt[(from + k) % NCH] > 0) return (from + k) % NCH;
    end
    return -1;
  endfunction

  // One clock per iteration: drive flags, compare, advance the model, pop FIFOs.
  task automatic applyStimulus(input int n, input bit doCheck = 1'b1);
    logic [NCH-1:0] expStrobe;
    bit             expRd;
    bit             leave;
    int             g;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NCH; c++) fifoEmpty[c] = (cnt[c] == 0);
      #1;
      expRd     = rst && mMode == 2 && outReady && cnt[mChan] > 0;
      expStrobe = '0;
      if (expRd) expStrobe[mChan] = 1'b1;
      if (doCheck) begin
        checkOutput("strobe", fifoReadEnable, expStrobe);
        checkOutput("chid", chidValue, mChan);
        checkOutput("data_valid", dataValid, mDv);
        checkOutput("data_chid", dataChid, mDchid);
        checkOutput("busy", busy, (mMode != 0 || mDv != 0));
      end
      if (fifoReadEnable != '0) strobeLog.push_back(int'(chidValue));
      if (!rst) begin
        mMode = 0; mPtr = 0; mChan = 0; mReads = 0; mDv = 0; mDchid = 0;
      end else begin
        mDv    = expRd;
        mDchid = mChan;
        if (mMode == 0) begin
          if (start && !stop) mMode = 1;
        end else if (mMode == 1) begin
          g = firstNonEmpty(mPtr);
          if (stop) mMode = 0;
          else if (g >= 0) begin
            mChan = g; mReads = 0; mMode = 2;
          end
        end else begin
          if (expRd) mReads++;
          leave = stop || (expRd && mReads == MAX_BURST) || cnt[mChan] == 0;
          if (leave) begin
            mPtr  = (mChan + 1) % NCH;
            mMode = stop ? 0 : 1;
          end
        end
        if (expRd) cnt[mChan]--;
      end
      @(negedge clk);
    end
  endtask

  task automatic clearFifos();
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
  endtask

  task automatic resetDut();
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    applyStimulus(2);
    rst = 1'b1;
    strobeLog.delete();
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; stop = 1'b0; outReady = 1'b1;
    for (int c = 0; c < NCH; c++) cnt[c] = 2;

    // Reset held with start and every FIFO full: outputs quiet, first pop two clocks after release
    applyStimulus(1, 1'b0);
    applyStimulus(2);
    strobeLog.delete();
    rst = 1'b1;
    applyStimulus(3);
    checkOutput("reset_first_pop_count", strobeLog.size(), 1);
    checkOutput("reset_first_pop_chan", strobeLog[0], 0);

    // Single channel, 6 words: burst of 4, bubble, burst of 2
    resetDut(); clearFifos();
    cnt[5] = 6; start = 1'b1;
    applyStimulus(14);
    checkOutput("ch5_pops", strobeLog.size(), 6);
    foreach (strobeLog[i]) checkOutput("ch5_chan", strobeLog[i], 5);

    // Wrap-around: serve 77 to park the pointer at 78, then 78/79/0, then prove ptr=1
    resetDut(); clearFifos();
    cnt[77] = 1; start = 1'b1;
    applyStimulus(6);
    strobeLog.delete();
    cnt[78] = 1; cnt[79] = 1; cnt[0] = 1;
    applyStimulus(12);
    checkOutput("wrap_count", strobeLog.size(), 3);
    checkOutput("wrap_g0", strobeLog[0], 78);
    checkOutput("wrap_g1", strobeLog[1], 79);
    checkOutput("wrap_g2", strobeLog[2], 0);
    strobeLog.delete();
    cnt[0] = 1; cnt[1] = 1;
    applyStimulus(10);
    checkOutput("ptr_after_wrap", strobeLog[0], 1);

    // Backpressure after the second read of channel 3
    resetDut(); clearFifos();
    cnt[3] = 4; start = 1'b1; outReady = 1'b1;
    applyStimulus(4);
    outReady = 1'b0;
    applyStimulus(3);
    outReady = 1'b1;
    applyStimulus(4);
    checkOutput("bp_pops", strobeLog.size(), 4);

    // Stop on the second read of channel 10
    resetDut(); clearFifos();
    cnt[10] = 4; start = 1'b1;
    applyStimulus(3);
    stop = 1'b1; start = 1'b0;
    applyStimulus(1);
    stop = 1'b0;
    applyStimulus(3);
    checkOutput("stop_pops", strobeLog.size(), 2);

    // start and stop together in IDLE, then an all-empty search
    resetDut();
    for (int c = 0; c < NCH; c++) cnt[c] = 2;
    start = 1'b1; stop = 1'b1;
    applyStimulus(4);
    checkOutput("start_stop_pops", strobeLog.size(), 0);
    clearFifos();
    stop = 1'b0;
    applyStimulus(5);
    checkOutput("all_empty_pops", strobeLog.size(), 0);

    // Random traffic with backpressure, stops and occasional resets
    resetDut(); clearFifos();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int c;
        c = (i % 500 < 250) ? $urandom_range(0, NCH - 1) : 76 + $urandom_range(0, 7) % 8 % NCH;
        c = c % NCH;
        cnt[c] = cnt[c] + $urandom_range(1, 6);
      end
      outReady = ($urandom_range(0, 3) != 0);
      start    = $urandom_range(0, 1);
      stop     = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 299) != 0);
      applyStimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
